// File: rtl/ex1_agu_conv_shad.sv
// EX1 address-gen, converter and 32-bit SHAD/SHLD shifter, all combinational.
// Ports: clock/reset (unused), opUIxt/opShadL/regValRs/regValRt/regSrT in; outValAgu/outValCnv/outCnvSrT/outValShad32 out.
module ex1_agu_conv_shad (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  opUIxt,
  input  logic        opShadL,
  input  logic [63:0] regValRs,
  input  logic [63:0] regValRt,
  input  logic        regSrT,
  output logic [31:0] outValAgu,
  output logic [63:0] outValCnv,
  output logic        outCnvSrT,
  output logic [31:0] outValShad32
);

  // AGU: base + scaled index, wraps mod 2^32
  logic [1:0]  aguScale;
  logic [31:0] aguIdx;

  assign aguScale  = opUIxt[5:4];
  assign aguIdx    = regValRt[31:0] << aguScale;
  assign outValAgu = regValRs[31:0] + aguIdx;

  // Converter
  logic [5:0] cnvOp;

  assign cnvOp = opUIxt[5:0];

  always_comb begin
    outValCnv = regValRs;
    outCnvSrT = regSrT;
    unique case (cnvOp)
      6'h01: outValCnv = {{56{regValRs[7]}}, regValRs[7:0]};
      6'h02: outValCnv = {56'b0, regValRs[7:0]};
      6'h03: outValCnv = {{48{regValRs[15]}}, regValRs[15:0]};
      6'h04: outValCnv = {48'b0, regValRs[15:0]};
      6'h05: outValCnv = {{32{regValRs[31]}}, regValRs[31:0]};
      6'h06: outValCnv = {32'b0, regValRs[31:0]};
      6'h07: outValCnv = ~regValRs;
      6'h08: outValCnv = 64'd0 - regValRs;
      6'h09: outValCnv = {63'b0, regSrT};
      6'h0A: outValCnv = {63'b0, ~regSrT};
      6'h0C: begin
        outValCnv = {regValRs[62:0], regSrT};
        outCnvSrT = regValRs[63];
      end
      6'h0D: begin
        outValCnv = {regSrT, regValRs[63:1]};
        outCnvSrT = regValRs[0];
      end
      default: outValCnv = regValRs;
    endcase
  end

  // Shifter: Rt[7:0] is a signed count, sign picks direction
  logic [7:0]  shN;
  logic [31:0] shSrc;
  logic        shFill;
  logic [4:0]  negMag;
  logic [63:0] shrExt;
  logic        isZero;
  logic        posSmall;
  logic        posBig;
  logic        negSmall;
  logic        negBig;

  assign shN    = regValRt[7:0];
  assign shSrc  = regValRs[31:0];
  assign shFill = ~opShadL & shSrc[31];
  assign negMag = 5'd0 - shN[4:0];
  assign shrExt = {{32{shFill}}, shSrc} >> negMag;

  // Five disjoint count ranges; -32 (0xE0) falls in negBig
  assign isZero   = (shN == 8'd0);
  assign posSmall = ~shN[7] & (shN[6:5] == 2'b00) & (|shN[4:0]);
  assign posBig   = ~shN[7] & (|shN[6:5]);
  assign negSmall = shN[7] & (&shN[6:5]) & (|shN[4:0]);
  assign negBig   = shN[7] & ~negSmall;

  always_comb begin
    outValShad32 = shSrc;
    unique case (1'b1)
      isZero:   outValShad32 = shSrc;
      posSmall: outValShad32 = shSrc << shN[4:0];
      posBig:   outValShad32 = 32'd0;
      negSmall: outValShad32 = shrExt[31:0];
      negBig:   outValShad32 = {32{shFill}};
      default:  outValShad32 = shSrc;
    endcase
  end

  // No state: clock/reset exist only for interface uniformity
  logic unusedSig;

  assign unusedSig = ^{clock, reset, opUIxt[7:6],
                       regValRt[63:32], shrExt[63:32]};

endmodule

// File: tb/tb_ex1_agu_conv_shad.sv
// Scoreboard bench for ex1_agu_conv_shad.
// Stimulus pushes model results; a monitor pops and compares each cycle.
module tb_ex1_agu_conv_shad;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  opUIxt = '0;
  logic        opShadL = 1'b0;
  logic [63:0] regValRs = '0;
  logic [63:0] regValRt = '0;
  logic        regSrT = 1'b0;
  logic [31:0] outValAgu;
  logic [63:0] outValCnv;
  logic        outCnvSrT;
  logic [31:0] outValShad32;

  ex1_agu_conv_shad dut (
    .clock(clock),
    .reset(reset),
    .opUIxt(opUIxt),
    .opShadL(opShadL),
    .regValRs(regValRs),
    .regValRt(regValRt),
    .regSrT(regSrT),
    .outValAgu(outValAgu),
    .outValCnv(outValCnv),
    .outCnvSrT(outCnvSrT),
    .outValShad32(outValShad32)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] agu;
    logic [63:0] cnv;
    logic        srt;
    logic [31:0] shad;
  } exp_t;

  exp_t expQ[$];
  int nCmp = 0;
  int nBad = 0;

  function automatic logic [31:0] mAgu(logic [7:0] op,
      logic [63:0] rs, logic [63:0] rt);
    longint unsigned sum;
    int unsigned mul;
    mul = 1 << op[5:4];
    sum = longint'(rs[31:0]) + longint'(rt[31:0]) * mul;
    return sum[31:0];
  endfunction

  function automatic logic [63:0] mCnv(logic [7:0] op,
      logic [63:0] rs, logic t);
    case (op & 8'h3F)
      8'h01: return longint'(byte'(rs[7:0]));
      8'h02: return rs & 64'hFF;
      8'h03: return longint'(shortint'(rs[15:0]));
      8'h04: return rs & 64'hFFFF;
      8'h05: return longint'(int'(rs[31:0]));
      8'h06: return rs & 64'hFFFF_FFFF;
      8'h07: return rs ^ 64'hFFFF_FFFF_FFFF_FFFF;
      8'h08: return -rs;
      8'h09: return t ? 64'd1 : 64'd0;
      8'h0A: return t ? 64'd0 : 64'd1;
      8'h0C: return (rs << 1) | (t ? 64'd1 : 64'd0);
      8'h0D: return (rs >> 1) | (t ? 64'h8000_0000_0000_0000 : 64'd0);
      default: return rs;
    endcase
  endfunction

  function automatic logic mSrt(logic [7:0] op, logic [63:0] rs, logic t);
    if ((op & 8'h3F) == 8'h0C) return rs[63];
    if ((op & 8'h3F) == 8'h0D) return rs[0];
    return t;
  endfunction

  function automatic logic [31:0] mShad(logic l,
      logic [63:0] rs, logic [63:0] rt);
    int n;
    int m;
    int v;
    logic [31:0] r;
    r = rs[31:0];
    n = int'(byte'(rt[7:0]));
    if (n >= 32) return 32'd0;
    if (n >= 0) return r << n;
    m = -n;
    if (l) return (m >= 32) ? 32'd0 : (r >> m);
    v = int'(r);
    if (m >= 32) return (v < 0) ? 32'hFFFF_FFFF : 32'd0;
    return 32'(v >>> m);
  endfunction

  task automatic drive(string tag, logic [7:0] op, logic l,
      logic [63:0] rs, logic [63:0] rt, logic t, logic rst,
      output exp_t e);
    @(negedge clock);
    opUIxt = op;
    opShadL = l;
    regValRs = rs;
    regValRt = rt;
    regSrT = t;
    reset = rst;
    e.tag = tag;
    e.agu = mAgu(op, rs, rt);
    e.cnv = mCnv(op, rs, t);
    e.srt = mSrt(op, rs, t);
    e.shad = mShad(l, rs, rt);
  endtask

  task automatic issue(string tag, logic [7:0] op, logic l,
      logic [63:0] rs, logic [63:0] rt, logic t, logic rst);
    exp_t e;
    drive(tag, op, l, rs, rt, t, rst, e);
    expQ.push_back(e);
  endtask

  task automatic cmp(string nm, string tag,
      logic [63:0] act, logic [63:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s/%s: got %h want %h", tag, nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        cmp("agu", e.tag, 64'(outValAgu), 64'(e.agu));
        cmp("cnv", e.tag, outValCnv, e.cnv);
        cmp("srt", e.tag, 64'(outCnvSrT), 64'(e.srt));
        cmp("shad", e.tag, 64'(outValShad32), 64'(e.shad));
      end
    end
  end

  initial begin : stim
    exp_t e;
    logic [63:0] rs;
    logic [63:0] rt;
    logic [7:0] op;
    logic [7:0] cnts[8];
    int waitCyc;
    cnts = '{8'h00, 8'h1F, 8'h20, 8'h7F, 8'hE1, 8'hE0, 8'h80, 8'hFF};

    // Reset asserted from the start: outputs still follow inputs
    issue("rst0", 8'h30, 1'b0, 64'h1000, 64'h10, 1'b0, 1'b1);

    // Directed points with hand-derived values
    drive("agu8", 8'h30, 1'b0, 64'h1000, 64'h10, 1'b0, 1'b0, e);
    e.agu = 32'h0000_1080;
    expQ.push_back(e);
    drive("aguWrap", 8'h20, 1'b0, 64'hFFFF_FFF8, 64'h2, 1'b1, 1'b0, e);
    e.agu = 32'h0;
    expQ.push_back(e);
    drive("sx16", 8'h03, 1'b0, 64'h80F0, 64'h0, 1'b1, 1'b0, e);
    e.cnv = 64'hFFFF_FFFF_FFFF_80F0;
    e.srt = 1'b1;
    expQ.push_back(e);
    drive("zx16", 8'hC4, 1'b0, 64'h80F0, 64'h0, 1'b0, 1'b0, e);
    e.cnv = 64'h80F0;
    e.srt = 1'b0;
    expQ.push_back(e);
    drive("neg", 8'h08, 1'b0, 64'h1, 64'h0, 1'b1, 1'b0, e);
    e.cnv = 64'hFFFF_FFFF_FFFF_FFFF;
    e.srt = 1'b1;
    expQ.push_back(e);
    drive("rotl", 8'h0C, 1'b0, 64'h8000_0000_0000_0001, 64'h0,
          1'b0, 1'b0, e);
    e.cnv = 64'h2;
    e.srt = 1'b1;
    expQ.push_back(e);
    drive("rotr", 8'h0D, 1'b0, 64'h8000_0000_0000_0001, 64'h0,
          1'b0, 1'b0, e);
    e.cnv = 64'h4000_0000_0000_0000;
    e.srt = 1'b1;
    expQ.push_back(e);
    drive("sar4", 8'h00, 1'b0, 64'hDEAD_0000_8000_0010,
          64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, e);
    e.shad = 32'hF800_0001;
    expQ.push_back(e);
    drive("shr4", 8'h00, 1'b1, 64'h8000_0010, 64'hFC, 1'b0, 1'b0, e);
    e.shad = 32'h0800_0001;
    expQ.push_back(e);
    drive("shl4", 8'h00, 1'b0, 64'h8000_0010, 64'hAB04, 1'b0, 1'b0, e);
    e.shad = 32'h0000_0100;
    expQ.push_back(e);
    drive("shl32", 8'h00, 1'b0, 64'h8000_0000, 64'h20, 1'b0, 1'b0, e);
    e.shad = 32'h0;
    expQ.push_back(e);
    drive("sar32", 8'h00, 1'b0, 64'h8000_0000, 64'hE0, 1'b0, 1'b0, e);
    e.shad = 32'hFFFF_FFFF;
    expQ.push_back(e);
    drive("shr128", 8'h00, 1'b1, 64'h8000_0000, 64'h80, 1'b0, 1'b0, e);
    e.shad = 32'h0;
    expQ.push_back(e);
    drive("sh0", 8'h00, 1'b1, 64'h8000_0000, 64'h100, 1'b0, 1'b0, e);
    e.shad = 32'h8000_0000;
    expQ.push_back(e);

    // Reset pulse while inputs are held
    for (int i = 0; i < 5; i++) begin
      drive("rstHold", 8'h30, 1'b0, 64'h1000, 64'h10, 1'b0,
            (i >= 1 && i <= 3), e);
      e.agu = 32'h0000_1080;
      expQ.push_back(e);
    end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rs = {$urandom, $urandom};
      rt = {$urandom, $urandom};
      op = 8'($urandom);
      if ($urandom_range(0, 1) == 1) op[3:0] = 4'($urandom_range(0, 13));
      if ($urandom_range(0, 2) == 0) op[5:4] = 2'b00;
      if ($urandom_range(0, 2) == 0) rt[7:0] = cnts[$urandom_range(0, 7)];
      issue("rand", op, 1'($urandom), rs, rt, 1'($urandom),
            ($urandom_range(0, 7) == 0));
    end

    waitCyc = 0;
    while (expQ.size() != 0 && waitCyc < 20) begin
      @(posedge clock);
      waitCyc++;
    end
    #2;
    if (expQ.size() != 0) begin
      nCmp++;
      nBad++;
      $display("FAIL drain: got %0d left want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/ex1_agu_conv_shad.md
EX1_AGU_CONV_SHAD -- requirements
Module: ex1_agu_conv_shad

Interface
REQ-001 SHALL have exactly these ports (clock and reset first); one clock; reset is synchronous and active-high:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opUIxt  input  8  sub-operation select
- opShadL  input  1  shift kind: 0 = arithmetic (SHAD), 1 = logical (SHLD)
- regValRs  input  64  source A (base / convert / shift value)
- regValRt  input  64  source B (index / shift count)
- regSrT  input  1  current SR.T flag
- outValAgu  output  32  effective address
- outValCnv  output  64  conversion result
- outCnvSrT  output  1  SR.T after conversion
- outValShad32  output  32  32-bit shift result

Function
REQ-002 SHALL compute all three outputs combinationally from current inputs: zero-cycle latency, no handshake, all units evaluated every cycle in parallel.
REQ-003 AGU SHALL output Rs[31:0] + (Rt[31:0] << s) modulo 2^32, with s = opUIxt[5:4] (00 = x1, 01 = x2, 10 = x4, 11 = x8); carry out is discarded and wrap-around is silent.
REQ-004 Converter SHALL select its operation with opUIxt[5:0] as follows:
- 0x00: Rs
- 0x01: sign-extend Rs[7:0]
- 0x02: zero-extend Rs[7:0]
- 0x03: sign-extend Rs[15:0]
- 0x04: zero-extend Rs[15:0]
- 0x05: sign-extend Rs[31:0]
- 0x06: zero-extend Rs[31:0]
- 0x07: bitwise NOT Rs
- 0x08: two's-complement negate Rs, mod 2^64
- 0x09: {63'b0, regSrT}
- 0x0A: {63'b0, !regSrT}
- 0x0C: rotate-through-T left: {Rs[62:0], regSrT}
- 0x0D: rotate-through-T right: {regSrT, Rs[63:1]}
- any other code: Rs
REQ-005 outCnvSrT SHALL be Rs[63] for 0x0C, Rs[0] for 0x0D, and regSrT for every other code.
REQ-006 opUIxt[7:6] SHALL be ignored by all units.
REQ-007 Shifter SHALL treat Rt[7:0] as a signed count n (-128..127); Rt[63:8] SHALL be ignored.
REQ-008 For n = 0, outValShad32 SHALL equal Rs[31:0].
REQ-009 For 1 <= n <= 31, outValShad32 SHALL be Rs[31:0] shifted left by n, zero fill.
REQ-010 For n >= 32, outValShad32 SHALL be 0.
REQ-011 For -31 <= n <= -1, outValShad32 SHALL be Rs[31:0] shifted right by -n, filled with Rs[31] when opShadL = 0 and with 0 when opShadL = 1.
REQ-012 For n <= -32, outValShad32 SHALL be 32'hFFFFFFFF when opShadL = 0 and Rs[31] = 1, and 0 otherwise.
REQ-013 Shifter SHALL use Rs[31:0] only; Rs[63:32] SHALL have no effect on outValShad32.
REQ-014 Outputs SHALL never be X or Z for known inputs; simultaneous use of all units SHALL need no arbitration.

Reset
REQ-015 The block SHALL hold no architectural state: clock and reset are kept for pipeline-interface uniformity only.
REQ-016 Asserting reset, including mid-stream, SHALL NOT alter any output; outputs SHALL depend on current inputs only, before, during and after reset.

Verification
REQ-017 AGU: Rs=0x0000_1000, Rt=0x10, opUIxt[5:4]=11 -> outValAgu=0x0000_1080; Rs=0xFFFF_FFF8, Rt=0x2, scale x4 -> outValAgu=0x0000_0000 (wrap).
REQ-018 Convert: Rs=0x0000_0000_0000_80F0, opUIxt=0x03 -> outValCnv=0xFFFF_FFFF_FFFF_80F0; opUIxt=0x04 -> 0x0000_0000_0000_80F0; opUIxt=0x08 with Rs=1 -> 0xFFFF_FFFF_FFFF_FFFF; outCnvSrT=regSrT in all three cases.
REQ-019 Rotate: Rs=0x8000_0000_0000_0001, regSrT=0, opUIxt=0x0C -> outValCnv=0x0000_0000_0000_0002, outCnvSrT=1; opUIxt=0x0D -> outValCnv=0x4000_0000_0000_0000, outCnvSrT=1.
REQ-020 Shift: Rs[31:0]=0x8000_0010, Rt[7:0]=0xFC (n=-4), opShadL=0 -> outValShad32=0xF800_0001; opShadL=1 -> 0x0800_0001; Rt[7:0]=0x04 -> 0x0000_0100.
REQ-021 Shift boundaries: Rs[31:0]=0x8000_0000 with n=32 -> 0; n=-32, opShadL=0 -> 0xFFFF_FFFF; n=-128, opShadL=1 -> 0; n=0 -> 0x8000_0000.
REQ-022 Reset transparency: hold REQ-017 inputs, pulse reset for 3 cycles -> outValAgu stays 0x0000_1080 on every cycle.
